// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply
// and restoring divide (one bit per cycle), valid/ready on both sides.
module alu_mc #(
    parameter int WIDTH      = 32,
    parameter int FUNC_WIDTH = 5,
    parameter int SHW        = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  ci,
    input  logic [FUNC_WIDTH-1:0] f,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      s,
    output logic                  co,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [FUNC_WIDTH-1:0] F_ADD   = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] F_SUB   = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] F_AND   = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] F_OR    = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] F_XOR   = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] F_SLL   = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] F_SRL   = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] F_SRA   = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] F_MUL   = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] F_MULHU = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] F_DIVU  = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] F_REMU  = FUNC_WIDTH'(11);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        s_q, s_d;
    logic                    co_q, co_d;
    logic                    err_q, err_d;
    logic [FUNC_WIDTH-1:0]   op_q, op_d;
    logic [SHW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]        a_q, a_d;
    logic [WIDTH-1:0]        b_q, b_d;
    logic [2*WIDTH-1:0]      prod_q, prod_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;

    logic [SHW-1:0]          shamt;
    logic [WIDTH:0]          addSum;
    logic [WIDTH:0]          subDiff;
    logic [WIDTH-1:0]        singleS;
    logic                    singleCo;
    logic                    singleErr;
    logic                    multiOp;

    logic [WIDTH:0]          mulSum;
    logic [2*WIDTH-1:0]      mulNext;
    logic [WIDTH:0]          divShift;
    logic [WIDTH:0]          divTrial;
    logic                    divFits;
    logic [WIDTH-1:0]        remNext;
    logic [WIDTH-1:0]        quoNext;
    logic                    divZero;

    assign shamt = b[SHW-1:0];

    always_comb begin
        singleS   = '0;
        singleCo  = 1'b0;
        singleErr = 1'b0;
        multiOp   = 1'b0;
        addSum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        subDiff   = {1'b0, a} - {1'b0, b};
        case (f)
            F_ADD: begin
                singleS  = addSum[WIDTH-1:0];
                singleCo = addSum[WIDTH];
            end
            F_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                singleS  = subDiff[WIDTH-1:0];
                singleCo = subDiff[WIDTH];
            end
            F_AND:   singleS = a & b;
            F_OR:    singleS = a | b;
            F_XOR:   singleS = a ^ b;
            F_SLL:   singleS = a << shamt;
            F_SRL:   singleS = a >> shamt;
            F_SRA:   singleS = $unsigned($signed(a) >>> shamt);
            F_MUL, F_MULHU, F_DIVU, F_REMU: multiOp = 1'b1;
            default: singleErr = 1'b1;
        endcase
    end

    // Low half of prod_q holds the remaining multiplier bits; the product
    // shifts in from the top as those bits are consumed.
    always_comb begin
        mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mulNext  = {mulSum, prod_q[WIDTH-1:1]};
        divShift = {rem_q, quo_q[WIDTH-1]};
        divTrial = divShift - {1'b0, b_q};
        divFits  = !divTrial[WIDTH];
        remNext  = divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
        quoNext  = {quo_q[WIDTH-2:0], divFits};
        divZero  = (b_q == '0);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        co_d    = co_q;
        err_d   = err_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = f;
                    a_d  = a;
                    b_d  = b;
                    if (multiOp) begin
                        state_d = BUSY;
                        cnt_d   = SHW'(WIDTH - 1);
                        prod_d  = {{WIDTH{1'b0}}, b};
                        rem_d   = '0;
                        quo_d   = a;
                    end else begin
                        state_d = DONE;
                        s_d     = singleS;
                        co_d    = singleCo;
                        err_d   = singleErr;
                    end
                end
            end
            BUSY: begin
                prod_d = mulNext;
                rem_d  = remNext;
                quo_d  = quoNext;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    co_d    = 1'b0;
                    err_d   = 1'b0;
                    case (op_q)
                        F_MUL:   s_d = mulNext[WIDTH-1:0];
                        F_MULHU: s_d = mulNext[2*WIDTH-1:WIDTH];
                        F_DIVU: begin
                            s_d   = divZero ? '1 : quoNext;
                            err_d = divZero;
                        end
                        default: begin
                            s_d   = divZero ? a_q : remNext;
                            err_d = divZero;
                        end
                    endcase
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            co_q    <= co_d;
            err_q   <= err_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign co        = co_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: scoreboard queue filled at accept, drained by a monitor on
// each output handshake; expectations come from a plain arithmetic model.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, ci, out_valid, out_ready, co, err;
    logic [W-1:0] a, b, s;
    logic [4:0]   f;

    logic         in_valid32, in_ready32, ci32, out_valid32, out_ready32, co32, err32;
    logic [31:0]  a32, b32, s32;
    logic [4:0]   f32;

    alu_mc #(.WIDTH(W), .FUNC_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .f(f), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .err(err)
    );

    alu_mc #(.WIDTH(32), .FUNC_WIDTH(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .ci(ci32), .f(f32), .out_valid(out_valid32),
        .out_ready(out_ready32), .s(s32), .co(co32), .err(err32)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         err;
    } resp_t;

    resp_t expQ[$];
    int    total = 0;
    int    bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t model(input logic [4:0] fn, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input logic c);
        resp_t          r;
        int unsigned    amt;
        logic [W:0]     sum;
        logic [2*W-1:0] p;
        r   = '0;
        amt = y % W;
        p   = x * y;
        case (fn)
            5'd0: begin
                sum  = x + y + c;
                r.s  = sum[W-1:0];
                r.co = sum[W];
            end
            5'd1: begin
                r.s  = W'(x - y);
                r.co = (x < y);
            end
            5'd2: r.s = x & y;
            5'd3: r.s = x | y;
            5'd4: r.s = x ^ y;
            5'd5: r.s = W'(x << amt);
            5'd6: r.s = x >> amt;
            5'd7: r.s = (x >> amt) | (x[W-1] ? ~({W{1'b1}} >> amt) : '0);
            5'd8: r.s = p[W-1:0];
            5'd9: r.s = p[2*W-1:W];
            5'd10: begin
                if (y == 0) begin r.s = '1; r.err = 1'b1; end
                else r.s = x / y;
            end
            5'd11: begin
                if (y == 0) begin r.s = x; r.err = 1'b1; end
                else r.s = x % y;
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Monitor: one pop per output transfer (handshake completes at the next edge).
    always @(negedge clk) begin : monitor
        resp_t e;
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedOutput", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("resultS", s, e.s);
                checkOutput("resultCo", co, e.co);
                checkOutput("resultErr", err, e.err);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] fn, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c, input int hold);
        int    lat;
        int    expLat;
        resp_t r;
        r      = model(fn, x, y, c);
        expLat = (fn >= 8 && fn <= 11) ? W : 0;
        f = fn; a = x; b = y; ci = c;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        checkOutput("inReadyIdle", in_ready, 1);
        expQ.push_back(r);
        @(posedge clk); #1;
        // Keep in_valid high with junk operands: the block must ignore them.
        a = W'($urandom); b = W'($urandom); f = 5'($urandom); ci = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            checkOutput("inReadyBusy", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, expLat);
        checkOutput("inReadyDone", in_ready, 0);
        if (hold > 0) begin
            repeat (hold) begin
                checkOutput("holdS", s, r.s);
                checkOutput("holdValid", out_valid, 1);
                checkOutput("holdInReady", in_ready, 0);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("validDrop", out_valid, 0);
        checkOutput("inReadyBack", in_ready, 1);
    endtask

    task automatic runWide(input logic [4:0] fn, input logic [31:0] x, input logic [31:0] y);
        int          lat;
        logic [63:0] p;
        logic [31:0] expS;
        p    = 64'(x) * 64'(y);
        expS = (fn == 5'd9) ? p[63:32] : p[31:0];
        f32 = fn; a32 = x; b32 = y; ci32 = 1'b0;
        in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(negedge clk);
        checkOutput("wideInReady", in_ready32, 1);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 0;
        while (!out_valid32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("wideLatency", lat, 32);
        checkOutput("wideS", s32, expS);
        checkOutput("wideErr", err32, 0);
        @(posedge clk); #1;
        checkOutput("wideValidDrop", out_valid32, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [4:0]   fn;
        logic [W-1:0] x, y;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; f = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; ci32 = 1'b0; f32 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstS", s, 0);
        checkOutput("rstCo", co, 0);
        checkOutput("rstErr", err, 0);

        applyStimulus(5'd0, 8'h01, 8'h02, 1'b0, 0);
        applyStimulus(5'd0, 8'hFF, 8'h01, 1'b1, 0);
        applyStimulus(5'd1, 8'h05, 8'h07, 1'b0, 0);
        applyStimulus(5'd7, 8'h80, 8'h03, 1'b0, 0);
        applyStimulus(5'd5, 8'h01, 8'h0F, 1'b0, 1);
        applyStimulus(5'd6, 8'hB4, 8'h02, 1'b0, 0);
        applyStimulus(5'd2, 8'hCC, 8'hAA, 1'b1, 0);
        applyStimulus(5'd3, 8'hCC, 8'hAA, 1'b0, 0);
        applyStimulus(5'd4, 8'hCC, 8'hAA, 1'b0, 0);
        applyStimulus(5'd8, 8'hFF, 8'hFF, 1'b0, 0);
        applyStimulus(5'd9, 8'hFF, 8'hFF, 1'b0, 0);
        applyStimulus(5'd10, 8'd200, 8'd7, 1'b0, 5);
        applyStimulus(5'd11, 8'd200, 8'd7, 1'b0, 0);
        applyStimulus(5'd10, 8'h05, 8'h00, 1'b0, 0);
        applyStimulus(5'd11, 8'h05, 8'h00, 1'b0, 2);
        applyStimulus(5'd20, 8'h12, 8'h34, 1'b1, 0);

        // Reset in the middle of a multiply discards it entirely.
        f = 5'd8; a = 8'h37; b = 8'h59; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checkOutput("abortInReady", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abortInReady", in_ready, 1);
        checkOutput("abortOutValid", out_valid, 0);
        checkOutput("abortS", s, 0);
        repeat (W + 3) begin
            @(posedge clk); #1;
            checkOutput("abortNoOutput", out_valid, 0);
        end

        for (int i = 0; i < 60; i++) begin
            fn = 5'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) fn = 5'($urandom_range(12, 31));
            x = W'($urandom);
            y = W'($urandom);
            if ((fn == 5'd10 || fn == 5'd11) && $urandom_range(0, 3) == 0) y = '0;
            applyStimulus(fn, x, y, 1'($urandom), $urandom_range(0, 3));
        end

        runWide(5'd8, 32'hFFFF_FFFF, 32'h0000_0002);
        runWide(5'd9, 32'hFFFF_FFFF, 32'h0000_0002);
        runWide(5'd8, 32'($urandom), 32'($urandom));

        repeat (2) @(posedge clk);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the combinational ALU in the C-Trino execute stage.
- Single-cycle ops (add/sub/logic/shift) complete in one cycle.
- Multiply and divide run iteratively: shift-add and restoring division, one bit per cycle.
- Valid/ready handshakes on both sides let the pipeline stall on long ops.

Parameters:
- WIDTH, 32, operand/result width in bits; minimum 4.
- FUNC_WIDTH, 5, width of function-select input.
- SHW, $clog2(WIDTH), derived; shift-amount bits taken from b[SHW-1:0].

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and function present.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (ADD only).
- f  in  FUNC_WIDTH  function select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- co  out  1  carry-out / borrow.
- err  out  1  illegal function code or divide by zero.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, co=0, err=0, all iteration registers 0.
- Reset mid-operation aborts the op and discards any held result; no out_valid follows.
- Function codes:
  - 0 ADD: {co,s}=a+b+ci.
  - 1 SUB: s=a-b; co=1 iff a<b unsigned (borrow).
  - 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount b[SHW-1:0]).
  - 8 MUL: low WIDTH bits of a*b unsigned.
  - 9 MULHU: high WIDTH bits of a*b unsigned.
  - 10 DIVU: quotient. 11 REMU: remainder.
  - co=0 for all codes other than ADD and SUB.
  - Codes 12..2^FUNC_WIDTH-1: s=0, co=0, err=1, single-cycle.
- Accept: transfer occurs when in_valid && in_ready at a rising edge; a, b, ci, f are captured.
- FSM: IDLE, BUSY, DONE.
  - IDLE + accept of a single-cycle op -> DONE; result registered that edge, out_valid=1 next cycle (latency 1).
  - IDLE + accept of MUL/MULHU/DIVU/REMU -> BUSY with iteration counter=WIDTH-1.
  - BUSY: one partial-product / trial-subtract step per cycle; counter decrements.
  - BUSY, step with counter==0 -> DONE; out_valid asserted exactly WIDTH cycles after the accept edge.
  - DONE: s/co/err held stable while out_valid=1 && !out_ready.
  - DONE + out_ready -> IDLE; out_valid drops next cycle.
- in_ready=1 only in IDLE; no back-to-back acceptance while a result is held. Max throughput: one op per 2 cycles.
- in_valid low or inputs changing during BUSY/DONE are ignored.
- Divide by zero (b=0): result is ready with the normal WIDTH-cycle latency.
  - DIVU: s=all ones, err=1. REMU: s=a, err=1.
- Multiply is unsigned, 2*WIDTH-bit internal product.
- Division is unsigned restoring, WIDTH-bit quotient and remainder.

Test Plan (WIDTH=8 unless noted):
- Reset then ADD a=0x01 b=0x02 ci=0 -> out_valid one cycle after accept, s=0x03 co=0 err=0; ADD 0xFF+0x01 ci=1 -> s=0x01 co=1.
- SUB 0x05-0x07 -> s=0xFE co=1; SRA 0x80 by b=3 -> s=0xF0; SLL 0x01 by b=0x0F (amount 7) -> s=0x80.
- MUL 0xFF*0xFF -> s=0x01 after exactly 8 cycles; MULHU same operands -> s=0xFE; in_ready=0 throughout BUSY/DONE.
- DIVU 200/7 -> s=28; REMU 200/7 -> s=4; DIVU 5/0 -> s=0xFF err=1; REMU 5/0 -> s=0x05 err=1.
- Backpressure: hold out_ready=0 five cycles after DIVU completes -> s stable, in_ready=0; out_ready=1 -> out_valid drops, in_ready=1 next cycle.
- Assert rst during BUSY of a MUL -> next cycle in_ready=1, out_valid=0, s=0; illegal f=20 -> s=0 err=1 after 1 cycle; repeat MUL with WIDTH=32: 0xFFFFFFFF*2 -> s=0xFFFFFFFE after 32 cycles.
